data_mem_responder: RTL

- Memory-side responder for the processor's data-memory interface: accepts one load/store request at a time over a valid/ready handshake and returns a response after a configurable wait.
- Replaces the zero-latency data memory behind the datapath so the core and future cache/stall logic can be exercised against realistic memory timing.
- Word-addressed storage with byte-enable writes. Misaligned and out-of-range accesses are reported as errors.

---
 rtl/data_mem_responder_pkg.sv | 27 ++
 rtl/data_mem_responder_if.sv | 30 +++
 rtl/data_mem_responder_word_array.sv | 31 +++
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  // Responder control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES       = 4;
  localparam int BYTE_OFFSET_BITS = 2;

  // The wait counter must hold LATENCY-1 for LATENCY up to 15.
  function automatic int wait_cnt_width();
    return 4;
  endfunction

  localparam int CNT_W = wait_cnt_width();

  // Registered response contents.
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } resp_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core's data port and the memory responder.
//
// Handshake rules: a request transfers on a rising edge where reqValid and
// reqReady are both high; the req* payload is only sampled on that edge. A
// response transfers on a rising edge where respValid and respReady are both
// high; while respValid is high and respReady is low, resp* stay stable.
interface data_mem_responder_if;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [31:0] reqAddr;
  logic [31:0] reqWData;
  logic [3:0]  reqByteEn;
  logic        respValid;
  logic        respReady;
  logic [31:0] respRData;
  logic        respError;

  // Requester side (core / cache).
  modport master (
    output reqValid, reqWrite, reqAddr, reqWData, reqByteEn, respReady,
    input  reqReady, respValid, respRData, respError
  );

  // Memory side.
  modport slave (
    input  reqValid, reqWrite, reqAddr, reqWData, reqByteEn, respReady,
    output reqReady, respValid, respRData, respError
  );
endinterface

// File: rtl/data_mem_responder_word_array.sv
// Word-wide storage with per-byte-lane synchronous write and combinational read.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] byteEn,
  input  logic [AW-1:0]         index,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Replace only the enabled byte lanes of the addressed word.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (byteEn[i]) begin
          mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the data port: one outstanding load/store, a
// programmable wait before the response, byte-enable writes and error
// reporting for misaligned or out-of-range addresses.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output state_e               dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  resp_t             resp_q, resp_d;

  logic              lat_write_q;
  logic [31:0]       lat_addr_q;
  logic [31:0]       lat_wdata_q;
  logic [3:0]        lat_be_q;

  logic              accept;
  logic              commit;
  logic              c_write;
  logic [31:0]       c_addr;
  logic [31:0]       c_wdata;
  logic [3:0]        c_be;
  logic              c_error;
  logic [AW-1:0]     c_index;
  logic              arr_we;
  logic [31:0]       arr_rdata;

  assign accept = (state_q == IDLE) && bus.reqValid;

  // Capture the request payload on the accept edge only; later req* changes are ignored.
  always_ff @(posedge clock) begin
    if (accept) begin
      lat_write_q <= bus.reqWrite;
      lat_addr_q  <= bus.reqAddr;
      lat_wdata_q <= bus.reqWData;
      lat_be_q    <= bus.reqByteEn;
    end
  end

  // Commit operands: with zero latency the commit happens on the accept edge,
  // so the live request is used; otherwise the captured copy.
  always_comb begin
    c_write = lat_write_q;
    c_addr  = lat_addr_q;
    c_wdata = lat_wdata_q;
    c_be    = lat_be_q;
    if (state_q == IDLE) begin
      c_write = bus.reqWrite;
      c_addr  = bus.reqAddr;
      c_wdata = bus.reqWData;
      c_be    = bus.reqByteEn;
    end
  end

  // Misaligned or beyond the stored words; the index is only meaningful when this is clear.
  assign c_error = (c_addr[BYTE_OFFSET_BITS-1:0] != '0) ||
                   ({2'b00, c_addr[31:BYTE_OFFSET_BITS]} >= 32'(DEPTH_WORDS));
  assign c_index = c_addr[AW+BYTE_OFFSET_BITS-1:BYTE_OFFSET_BITS];

  // A reset on the commit edge must leave memory untouched.
  assign arr_we = commit && c_write && !c_error && !reset;

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clock  (clock),
    .we     (arr_we),
    .byteEn (c_be),
    .index  (c_index),
    .wdata  (c_wdata),
    .rdata  (arr_rdata)
  );

  // Next-state, wait counter and commit decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.reqValid) begin
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.respReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response payload is produced on the commit edge and then held.
  always_comb begin
    resp_d = resp_q;
    if (commit) begin
      resp_d.error = c_error;
      resp_d.rdata = (c_write || c_error) ? 32'h0 : arr_rdata;
    end
  end

  // State, counter and response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.reqReady  = (state_q == IDLE);
  assign bus.respValid = (state_q == RESP);
  assign bus.respRData = resp_q.rdata;
  assign bus.respError = resp_q.error;
  assign dbg_state     = state_q;

endmodule
